// File: rtl/comb_mc.sv
// Multi-channel CIC comb stage: y = x[n] - x[n-M] per channel.
// Delay lines are gated by a fill counter, so storage never needs reset.
module comb_mc #(
  parameter int DATA_WIDTH = 1,
  parameter int DELAY      = 250,
  parameter int NUM_CH     = 1,
  parameter int IN_SIGNED  = 0,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic [CW-1:0]         ch_i,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  valid_o,
  output logic [CW-1:0]         ch_o,
  output logic                  primed_o
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int FW = $clog2(DELAY + 1);
  localparam int DEPTH = NUM_CH * DELAY;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NCH = 2 ** CW;
  localparam logic [CW:0] CH_LIM = (CW + 1)'(NUM_CH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DELAY - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DELAY);

  logic [DW-1:0] dline_q [2**AW];
  logic [PW-1:0] ptr_q  [NCH];
  logic [PW-1:0] ptr_d  [NCH];
  logic [FW-1:0] fill_q [NCH];
  logic [FW-1:0] fill_d [NCH];

  logic          valid_q, valid_d;
  logic [DW:0]   data_q, data_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          primed_q, primed_d;

  logic          acc;
  logic          primed;
  logic [PW-1:0] cur_ptr;
  logic [FW-1:0] cur_fill;
  logic [AW-1:0] addr;
  logic [DW-1:0] old;
  logic [DW:0]   ext_new, ext_old;

  // Accept, read old sample, difference, and advance the channel state
  always_comb begin
    acc      = en_i && valid_i && ({1'b0, ch_i} < CH_LIM);
    cur_ptr  = ptr_q[ch_i];
    cur_fill = fill_q[ch_i];
    primed   = (cur_fill == FILL_FULL);
    addr     = AW'(int'(ch_i) * DELAY + int'(cur_ptr));
    old      = primed ? dline_q[addr] : '0;
    if (IN_SIGNED != 0) begin
      ext_new = {data_i[DW-1], data_i};
      ext_old = {old[DW-1], old};
    end else begin
      ext_new = {1'b0, data_i};
      ext_old = {1'b0, old};
    end
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    valid_d  = acc;
    data_d   = data_q;
    ch_d     = ch_q;
    primed_d = primed_q;
    if (!en_i) begin
      for (int i = 0; i < NCH; i++) begin
        ptr_d[i]  = '0;
        fill_d[i] = '0;
      end
    end else if (acc) begin
      ptr_d[ch_i] = (cur_ptr == PTR_LAST) ? '0 : cur_ptr + 1'b1;
      if (!primed) begin
        fill_d[ch_i] = cur_fill + 1'b1;
      end
    end
    if (acc) begin
      data_d   = ext_new - ext_old;
      ch_d     = ch_i;
      primed_d = primed;
    end
  end

  // Pointer, fill and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q    <= '{default: '0};
      fill_q   <= '{default: '0};
      valid_q  <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
      primed_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      primed_q <= primed_d;
    end
  end

  // Delay-line storage; stale contents are masked by the fill counter
  always_ff @(posedge clk_i) begin
    if (acc) begin
      dline_q[addr] <= data_i;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign ch_o     = ch_q;
  assign primed_o = primed_q;

endmodule

// File: tb/tb_comb_mc.sv
// Directed bench for comb_mc across several parameter sets.
// Each task drives one scenario and checks outputs 1ns after the edge.
module tb_comb_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // u1: DW=1 DELAY=4 NUM_CH=1 unsigned
  logic en1 = 0, vi1 = 0, vo1, po1;
  logic [0:0] di1 = '0, ci1 = '0, co1;
  logic [1:0] do1;
  // u2: DW=4 DELAY=2 signed
  logic en2 = 0, vi2 = 0, vo2, po2;
  logic [3:0] di2 = '0;
  logic [0:0] ci2 = '0, co2;
  logic [4:0] do2;
  // u3: DW=1 DELAY=2 NUM_CH=2 unsigned
  logic en3 = 0, vi3 = 0, vo3, po3;
  logic [0:0] di3 = '0, ci3 = '0, co3;
  logic [1:0] do3;
  // u4: DW=4 DELAY=2 NUM_CH=3 unsigned
  logic en4 = 0, vi4 = 0, vo4, po4;
  logic [3:0] di4 = '0;
  logic [1:0] ci4 = '0, co4;
  logic [4:0] do4;
  // u5: DW=4 DELAY=1 signed
  logic en5 = 0, vi5 = 0, vo5, po5;
  logic [3:0] di5 = '0;
  logic [0:0] ci5 = '0, co5;
  logic [4:0] do5;

  comb_mc #(.DATA_WIDTH(1), .DELAY(4), .NUM_CH(1), .IN_SIGNED(0)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en1), .data_i(di1),
    .valid_i(vi1), .ch_i(ci1), .data_o(do1), .valid_o(vo1),
    .ch_o(co1), .primed_o(po1));

  comb_mc #(.DATA_WIDTH(4), .DELAY(2), .NUM_CH(1), .IN_SIGNED(1)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en2), .data_i(di2),
    .valid_i(vi2), .ch_i(ci2), .data_o(do2), .valid_o(vo2),
    .ch_o(co2), .primed_o(po2));

  comb_mc #(.DATA_WIDTH(1), .DELAY(2), .NUM_CH(2), .IN_SIGNED(0)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en3), .data_i(di3),
    .valid_i(vi3), .ch_i(ci3), .data_o(do3), .valid_o(vo3),
    .ch_o(co3), .primed_o(po3));

  comb_mc #(.DATA_WIDTH(4), .DELAY(2), .NUM_CH(3), .IN_SIGNED(0)) u4 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en4), .data_i(di4),
    .valid_i(vi4), .ch_i(ci4), .data_o(do4), .valid_o(vo4),
    .ch_o(co4), .primed_o(po4));

  comb_mc #(.DATA_WIDTH(4), .DELAY(1), .NUM_CH(1), .IN_SIGNED(1)) u5 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en5), .data_i(di5),
    .valid_i(vi5), .ch_i(ci5), .data_o(do5), .valid_o(vo5),
    .ch_o(co5), .primed_o(po5));

  task automatic test_reset();
    #1;
    n_chk++;
    if ({vo1, do1, co1, po1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_u1 got %b want 00000", {vo1, do1, co1, po1});
    end
    n_chk++;
    if ({vo2, do2, co2, po2} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_u2 got %b want 0", {vo2, do2, co2, po2});
    end
    n_chk++;
    if ({vo3, do3, co3, po3} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_u3 got %b want 0", {vo3, do3, co3, po3});
    end
    n_chk++;
    if ({vo4, do4, co4, po4} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_u4 got %b want 0", {vo4, do4, co4, po4});
    end
    n_chk++;
    if ({vo5, do5, co5, po5} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_u5 got %b want 0", {vo5, do5, co5, po5});
    end
    @(negedge clk);
    rst_n = 1'b1;
    en1 = 1; en2 = 1; en3 = 1; en4 = 1; en5 = 1;
  endtask

  task automatic test_basic();
    int din[8] = '{1, 1, 0, 1, 0, 0, 1, 1};
    int exd[8] = '{1, 1, 0, 1, -1, -1, 1, 0};
    int exp_p[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vi1 = 1; di1 = 1'(din[i]);
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo1, do1, po1} !== {1'b1, 2'(exd[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL basic[%0d] got v%b d%0d p%b want d%0d p%0d",
                 i, vo1, $signed(do1), po1, exd[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi1 = 0;
  endtask

  task automatic test_signed();
    int din[4] = '{-8, 7, 7, -8};
    int exd[4] = '{-8, 7, 15, -15};
    int exp_p[4] = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vi2 = 1; di2 = 4'(din[i]);
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo2, do2, po2} !== {1'b1, 5'(exd[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL signed[%0d] got v%b d%0d p%b want d%0d p%0d",
                 i, vo2, $signed(do2), po2, exd[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi2 = 0;
  endtask

  task automatic test_multich();
    int cin[6] = '{0, 1, 0, 1, 0, 1};
    int din[6] = '{1, 0, 1, 1, 0, 1};
    int exd[6] = '{1, 0, 1, 1, -1, 1};
    int exp_p[6] = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vi3 = 1; ci3 = 1'(cin[i]); di3 = 1'(din[i]);
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo3, do3, co3, po3} !==
          {1'b1, 2'(exd[i]), 1'(cin[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL multich[%0d] got d%0d c%0d p%b want d%0d c%0d p%0d",
                 i, $signed(do3), co3, po3, exd[i], cin[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi3 = 0;
  endtask

  task automatic test_enable();
    int exd[5] = '{1, 1, 1, 1, 0};
    int exp_p[5] = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en1 = 0; vi1 = 1; di1 = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo1, do1, po1} !== 4'b0001) begin
        n_fail++;
        $display("FAIL disabled[%0d] got v%b d%b p%b want v0 d00 p1",
                 i, vo1, do1, po1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en1 = 1; vi1 = 1; di1 = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo1, do1, po1} !== {1'b1, 2'(exd[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL resume[%0d] got v%b d%0d p%b want d%0d p%0d",
                 i, vo1, $signed(do1), po1, exd[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi1 = 0;
  endtask

  task automatic test_async_reset();
    int din[5] = '{1, 0, 1, 1, 0};
    int exd[5] = '{1, 0, 1, 1, -1};
    int exp_p[5] = '{0, 0, 0, 0, 1};
    @(negedge clk);
    vi1 = 1; di1 = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({vo1, do1, po1} !== 4'b1111) begin
      n_fail++;
      $display("FAIL pre_reset got v%b d%b p%b want v1 d11 p1",
               vo1, do1, po1);
    end
    #2;
    rst_n = 0; vi1 = 0;
    #1;
    n_chk++;
    if ({vo1, do1, co1, po1} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset got %b want 00000", {vo1, do1, co1, po1});
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vi1 = 1; di1 = 1'(din[i]);
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo1, do1, po1} !== {1'b1, 2'(exd[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL post_reset[%0d] got v%b d%0d p%b want d%0d p%0d",
                 i, vo1, $signed(do1), po1, exd[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi1 = 0;
  endtask

  task automatic test_range();
    int vin[12] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    int cin[12] = '{0, 1, 0, 3, 0, 2, 1, 0, 1, 1, 2, 0};
    int din[12] = '{5, 3, 9, 15, 2, 7, 0, 4, 8, 1, 0, 0};
    int exv[12] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    int exd[12] = '{5, 3, 3, 3, 2, 7, 7, -1, 8, -2, 0, -2};
    int exc[12] = '{0, 1, 1, 1, 0, 2, 2, 0, 1, 1, 2, 0};
    int exp_p[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vi4 = 1'(vin[i]); ci4 = 2'(cin[i]); di4 = 4'(din[i]);
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo4, do4, co4, po4} !==
          {1'(exv[i]), 5'(exd[i]), 2'(exc[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL range[%0d] got v%b d%0d c%0d p%b want v%0d d%0d c%0d p%0d",
                 i, vo4, $signed(do4), co4, po4,
                 exv[i], exd[i], exc[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi4 = 0;
  endtask

  task automatic test_delay1();
    int din[3] = '{3, 5, -2};
    int exd[3] = '{3, 2, -7};
    int exp_p[3] = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vi5 = 1; di5 = 4'(din[i]);
      @(posedge clk);
      #1;
      n_chk++;
      if ({vo5, do5, po5} !== {1'b1, 5'(exd[i]), 1'(exp_p[i])}) begin
        n_fail++;
        $display("FAIL delay1[%0d] got v%b d%0d p%b want d%0d p%0d",
                 i, vo5, $signed(do5), po5, exd[i], exp_p[i]);
      end
    end
    @(negedge clk);
    vi5 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_multich();
    test_enable();
    test_async_reset();
    test_range();
    test_delay1();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
